// File: rtl/rgb_led_pkg.sv
// Shared types and default parameters for the RGB LED PWM stage and its
// colour producers.
package rgb_led_pkg;

   localparam int unsigned RGB_WIDTH    = 8;
   localparam int unsigned RGB_PRESCALE = 46;

   typedef logic [RGB_WIDTH-1:0] colour_t;

   typedef struct packed {
      colour_t r;
      colour_t g;
      colour_t b;
   } rgb_t;

endpackage

// File: rtl/rgb_led_pwm_channel.sv
// One PWM colour channel: active intensity register loaded on commit and a
// registered active-low compare output.
module rgb_led_pwm_channel
   import rgb_led_pkg::*;
#(
   parameter int unsigned WIDTH = RGB_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_pwm_cnt,
   input  logic [WIDTH-1:0] i_shadow,
   input  logic             i_commit,
   output logic             o_led_n
);

   logic [WIDTH-1:0] r_active;
   logic             r_led_n;
   logic             w_on;

   assign w_on    = (i_pwm_cnt < r_active);
   assign o_led_n = r_led_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active <= '0;
      end else if (i_commit) begin
         r_active <= i_shadow;
      end
   end

   // Full-scale active still leaves the final tick of each period dark.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_led_n <= 1'b1;
      end else begin
         r_led_n <= ~w_on;
      end
   end

endmodule

// File: rtl/rgb_led_pwm.sv
// RGB LED PWM stage: accepts colours over valid/ready and applies them only
// at PWM period boundaries, driving active-low LED pins.
module rgb_led_pwm
   import rgb_led_pkg::*;
#(
   parameter int unsigned WIDTH    = RGB_WIDTH,
   parameter int unsigned PRESCALE = RGB_PRESCALE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_r,
   input  logic [WIDTH-1:0] in_g,
   input  logic [WIDTH-1:0] in_b,
   output logic             period_tick,
   output logic             led_r,
   output logic             led_g,
   output logic             led_b
);

   localparam int unsigned PS_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

   typedef struct packed {
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] b;
   } pix_t;

   logic [PS_W-1:0]  r_prescale;
   logic [WIDTH-1:0] r_pwm_cnt;
   logic             r_period_tick;
   logic             r_pending;
   pix_t             r_shadow;

   logic             w_tick;
   logic             w_period_end;
   logic             w_xfer;
   logic             w_commit;

   assign w_tick       = (r_prescale == PS_W'(PRESCALE));
   assign w_period_end = w_tick && (r_pwm_cnt == {WIDTH{1'b1}});
   assign w_xfer       = in_valid && !r_pending;
   // Pending is sampled before this cycle's transfer, so a same-cycle
   // transfer waits a full period for its commit.
   assign w_commit     = w_period_end && r_pending;

   assign in_ready    = ~r_pending;
   assign period_tick = r_period_tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prescale <= '0;
      end else if (w_tick) begin
         r_prescale <= '0;
      end else begin
         r_prescale <= r_prescale + PS_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm_cnt     <= '0;
         r_period_tick <= 1'b0;
      end else begin
         r_period_tick <= w_period_end;
         if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= 1'b0;
         r_shadow  <= '0;
      end else if (w_xfer) begin
         r_pending <= 1'b1;
         r_shadow  <= '{r: in_r, g: in_g, b: in_b};
      end else if (w_commit) begin
         r_pending <= 1'b0;
      end
   end

   rgb_led_pwm_channel #(.WIDTH(WIDTH)) u_chan_r (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_pwm_cnt (r_pwm_cnt),
      .i_shadow  (r_shadow.r),
      .i_commit  (w_commit),
      .o_led_n   (led_r)
   );

   rgb_led_pwm_channel #(.WIDTH(WIDTH)) u_chan_g (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_pwm_cnt (r_pwm_cnt),
      .i_shadow  (r_shadow.g),
      .i_commit  (w_commit),
      .o_led_n   (led_g)
   );

   rgb_led_pwm_channel #(.WIDTH(WIDTH)) u_chan_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_pwm_cnt (r_pwm_cnt),
      .i_shadow  (r_shadow.b),
      .i_commit  (w_commit),
      .o_led_n   (led_b)
   );

endmodule
